// File: rtl/keypad_link.sv
// Keypad-side endpoint of the alarm controller links: deserializes the 4-bit
// status frame and replays buffered key digits to the controller's code checker.
module keypad_link #(
  parameter int DIGITS  = 4,
  parameter int KEY_GAP = 1
) (
  input  logic       CLK,
  input  logic       RESET_IN,
  input  logic       STATUS_OUT,
  input  logic       STATUS_SEND,
  output logic [1:0] KB_IN,
  output logic       KB_RECV,
  input  logic [1:0] digit_in,
  input  logic       digit_push,
  input  logic       submit,
  input  logic       clear,
  output logic       busy,
  output logic [2:0] buf_count,
  output logic       buf_full,
  output logic       armed,
  output logic       alarm,
  output logic       sensor1,
  output logic       sensor2,
  output logic       status_valid,
  output logic       frame_err
);

  localparam int IW = (DIGITS  > 1) ? $clog2(DIGITS)  : 1;
  localparam int GW = (KEY_GAP > 1) ? $clog2(KEY_GAP) : 1;
  localparam logic [2:0]    DIG_N  = 3'(DIGITS);
  localparam logic [GW-1:0] GAP_LD = GW'(KEY_GAP - 1);

  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_SHIFT = 1'b1;

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_DIGIT = 2'd1;
  localparam logic [1:0] T_GAP   = 2'd2;

  typedef struct packed {
    logic armed;
    logic alarm;
    logic sensor1;
    logic sensor2;
  } status_t;

  status_t    flags;
  logic [0:0] rstate;
  logic [1:0] rcnt;
  logic [2:0] rsh;

  // A strobe always restarts a frame; in R_SHIFT it also aborts the old one.
  always_ff @(posedge CLK) begin
    if (!RESET_IN) begin
      rstate       <= R_IDLE;
      rcnt         <= '0;
      rsh          <= '0;
      flags        <= '0;
      status_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (STATUS_SEND) begin
        frame_err <= (rstate == R_SHIFT);
        rsh       <= {2'b00, STATUS_OUT};
        rcnt      <= 2'd3;
        rstate    <= R_SHIFT;
      end else if (rstate == R_SHIFT) begin
        if (rcnt == 2'd1) begin
          flags        <= status_t'({rsh, STATUS_OUT});
          status_valid <= 1'b1;
          rstate       <= R_IDLE;
        end else begin
          rsh  <= {rsh[1:0], STATUS_OUT};
          rcnt <= rcnt - 2'd1;
        end
      end
    end
  end

  assign armed   = flags.armed;
  assign alarm   = flags.alarm;
  assign sensor1 = flags.sensor1;
  assign sensor2 = flags.sensor2;

  logic [1:0]              tstate;
  logic [DIGITS-1:0][1:0]  mem;
  logic [2:0]              cnt;
  logic [IW-1:0]           idx;
  logic [GW-1:0]           gcnt;

  // Buffer edits only happen in T_IDLE; submit > clear > push there.
  always_ff @(posedge CLK) begin
    if (!RESET_IN) begin
      tstate <= T_IDLE;
      mem    <= '0;
      cnt    <= '0;
      idx    <= '0;
      gcnt   <= '0;
    end else begin
      case (tstate)
        T_IDLE: begin
          if (submit) begin
            if (cnt != 3'd0) begin
              tstate <= T_DIGIT;
              idx    <= '0;
            end
          end else if (clear) begin
            cnt <= '0;
          end else if (digit_push && (cnt < DIG_N)) begin
            mem[cnt[IW-1:0]] <= digit_in;
            cnt              <= cnt + 3'd1;
          end
        end
        T_DIGIT: begin
          tstate <= T_GAP;
          gcnt   <= GAP_LD;
        end
        T_GAP: begin
          if (gcnt != '0) begin
            gcnt <= gcnt - 1'b1;
          end else if ((3'(idx) + 3'd1) == cnt) begin
            cnt    <= '0;
            tstate <= T_IDLE;
          end else begin
            idx    <= idx + 1'b1;
            tstate <= T_DIGIT;
          end
        end
        default: tstate <= T_IDLE;
      endcase
    end
  end

  assign KB_RECV   = (tstate == T_DIGIT);
  assign KB_IN     = KB_RECV ? mem[idx] : 2'b00;
  assign busy      = (tstate != T_IDLE);
  assign buf_count = cnt;
  assign buf_full  = (cnt == DIG_N);

endmodule

// File: tb/tb_keypad_link.sv
// Directed bench for keypad_link: buffer vector table plus hand-written
// status-frame, transmit and reset sequences.
module tb_keypad_link;

  logic       CLK = 1'b0;
  logic       RESET_IN = 1'b0;
  logic       STATUS_OUT = 1'b0;
  logic       STATUS_SEND = 1'b0;
  logic [1:0] digit_in = 2'd0;
  logic       digit_push = 1'b0;
  logic       submit = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] KB_IN;
  logic       KB_RECV, busy, buf_full;
  logic [2:0] buf_count;
  logic       armed, alarm, sensor1, sensor2, status_valid, frame_err;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  keypad_link #(.DIGITS(4), .KEY_GAP(1)) dut (
    .CLK(CLK), .RESET_IN(RESET_IN), .STATUS_OUT(STATUS_OUT), .STATUS_SEND(STATUS_SEND),
    .KB_IN(KB_IN), .KB_RECV(KB_RECV), .digit_in(digit_in), .digit_push(digit_push),
    .submit(submit), .clear(clear), .busy(busy), .buf_count(buf_count), .buf_full(buf_full),
    .armed(armed), .alarm(alarm), .sensor1(sensor1), .sensor2(sensor2),
    .status_valid(status_valid), .frame_err(frame_err)
  );

  typedef struct {
    int push, d, sub, clr;
    int cnt, full, bsy, recv, kb;
  } vec_t;

  vec_t tbl[16];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] flg();
    return 32'({armed, alarm, sensor1, sensor2});
  endfunction

  task automatic send_frame(input logic [3:0] b);
    for (int i = 0; i < 4; i++) begin
      STATUS_SEND = (i == 0);
      STATUS_OUT  = b[3-i];
      tick();
      if (i < 3) chk("frame_midvalid", 32'(status_valid), 0);
    end
    STATUS_SEND = 1'b0;
    STATUS_OUT  = 1'b0;
    chk("frame_valid", 32'(status_valid), 1);
    chk("frame_flags", flg(), 32'(b));
    chk("frame_err_quiet", 32'(frame_err), 0);
    tick();
    chk("frame_valid_drop", 32'(status_valid), 0);
  endtask

  task automatic push(input logic [1:0] d);
    digit_push = 1'b1;
    digit_in   = d;
    tick();
    digit_push = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0, 1,0,0,0,0};
    tbl[1]  = '{1,1,0,0, 2,0,0,0,0};
    tbl[2]  = '{1,2,0,0, 3,0,0,0,0};
    tbl[3]  = '{1,3,0,0, 4,1,0,0,0};
    tbl[4]  = '{1,0,0,0, 4,1,0,0,0};
    tbl[5]  = '{0,0,0,1, 0,0,0,0,0};
    tbl[6]  = '{1,2,0,1, 0,0,0,0,0};
    tbl[7]  = '{0,0,1,0, 0,0,0,0,0};
    tbl[8]  = '{1,3,0,0, 1,0,0,0,0};
    tbl[9]  = '{1,1,1,0, 1,0,1,1,3};
    tbl[10] = '{0,0,0,0, 1,0,1,0,0};
    tbl[11] = '{0,0,0,0, 0,0,0,0,0};
    tbl[12] = '{1,1,0,0, 1,0,0,0,0};
    tbl[13] = '{0,0,1,1, 1,0,1,1,1};
    tbl[14] = '{1,2,0,1, 1,0,1,0,0};
    tbl[15] = '{0,0,0,0, 0,0,0,0,0};

    // reset with random activity on every input
    RESET_IN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      STATUS_OUT  = 1'($urandom);
      STATUS_SEND = 1'($urandom);
      digit_in    = 2'($urandom);
      digit_push  = 1'($urandom);
      submit      = 1'($urandom);
      clear       = 1'($urandom);
      tick();
    end
    chk("rst_kb_in", 32'(KB_IN), 0);
    chk("rst_kb_recv", 32'(KB_RECV), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(buf_count), 0);
    chk("rst_full", 32'(buf_full), 0);
    chk("rst_flags", flg(), 0);
    chk("rst_valid", 32'(status_valid), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    STATUS_OUT = 0; STATUS_SEND = 0; digit_in = 0;
    digit_push = 0; submit = 0; clear = 0;
    RESET_IN = 1'b1;
    tick();

    send_frame(4'b1010);
    send_frame(4'b1100);

    // abort: a new strobe lands on the 3rd bit, which becomes bit3 of frame 0001
    STATUS_SEND = 1; STATUS_OUT = 1; tick();
    STATUS_SEND = 0; STATUS_OUT = 1; tick();
    STATUS_SEND = 1; STATUS_OUT = 0; tick();
    chk("abort_ferr", 32'(frame_err), 1);
    chk("abort_flags_hold", flg(), 32'b1100);
    chk("abort_novalid", 32'(status_valid), 0);
    STATUS_SEND = 0; STATUS_OUT = 0; tick();
    chk("abort_ferr_drop", 32'(frame_err), 0);
    STATUS_OUT = 0; tick();
    STATUS_OUT = 1; tick();
    STATUS_OUT = 0;
    chk("abort_new_valid", 32'(status_valid), 1);
    chk("abort_new_flags", flg(), 32'b0001);
    tick();

    // buffer vector table
    for (int i = 0; i < 16; i++) begin
      digit_push = 1'(tbl[i].push);
      digit_in   = 2'(tbl[i].d);
      submit     = 1'(tbl[i].sub);
      clear      = 1'(tbl[i].clr);
      tick();
      chk($sformatf("v%0d_count", i), 32'(buf_count), tbl[i].cnt);
      chk($sformatf("v%0d_full", i), 32'(buf_full), tbl[i].full);
      chk($sformatf("v%0d_busy", i), 32'(busy), tbl[i].bsy);
      chk($sformatf("v%0d_recv", i), 32'(KB_RECV), tbl[i].recv);
      chk($sformatf("v%0d_kb", i), 32'(KB_IN), tbl[i].kb);
    end
    digit_push = 0; submit = 0; clear = 0;

    // four-digit transmit with push and clear attempted while busy
    push(2'd0); push(2'd1); push(2'd2); push(2'd3);
    submit = 1; tick(); submit = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        digit_push = (c == 2);
        digit_in   = 2'd2;
        clear      = (c == 4);
        tick();
      end
      chk($sformatf("tx%0d_recv", c), 32'(KB_RECV), (c % 2 == 0) ? 1 : 0);
      chk($sformatf("tx%0d_kb", c), 32'(KB_IN), (c % 2 == 0) ? c / 2 : 0);
      chk($sformatf("tx%0d_busy", c), 32'(busy), 1);
      chk($sformatf("tx%0d_count", c), 32'(buf_count), 4);
    end
    digit_push = 0; clear = 0;
    tick();
    chk("tx_done_busy", 32'(busy), 0);
    chk("tx_done_count", 32'(buf_count), 0);
    chk("tx_done_recv", 32'(KB_RECV), 0);

    // reset in the middle of a status frame discards it
    STATUS_SEND = 1; STATUS_OUT = 1; tick();
    STATUS_SEND = 0; tick();
    RESET_IN = 0; tick();
    chk("rstf_flags", flg(), 0);
    RESET_IN = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstf_novalid%0d", i), 32'(status_valid), 0);
    end
    STATUS_OUT = 0;

    // reset after the second digit stops transmission
    push(2'd2); push(2'd3); push(2'd1);
    submit = 1; tick(); submit = 0;
    chk("rstx_d0", 32'(KB_IN), 2);
    tick(); tick();
    chk("rstx_d1", 32'(KB_IN), 3);
    RESET_IN = 0; tick();
    chk("rstx_recv", 32'(KB_RECV), 0);
    chk("rstx_busy", 32'(busy), 0);
    chk("rstx_count", 32'(buf_count), 0);
    RESET_IN = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rstx_quiet%0d", i), 32'(KB_RECV), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_link.md
Name: keypad_link

Overview:
- Keypad-side endpoint of the alarm controller's two serial links. It sits on the keypad/display board and runs on the controller's serial clock.
- Receive path: deserializes the 4-bit status frame sent on STATUS_OUT/STATUS_SEND into armed/alarm/sensor flags.
- Transmit path: buffers digits typed by the user and sends them on KB_IN/KB_RECV in the format the controller's code checker samples.

Parameters:
- DIGITS, 4, capacity of the digit buffer; a submitted code is at most DIGITS digits.
- KEY_GAP, 1, idle cycles (KB_RECV=0) inserted after each transmitted digit; must be ≥1.

Ports:
- CLK  in  1  serial clock shared with the controller (SERCLK_OUT); all logic on its rising edge.
- RESET_IN  in  1  synchronous reset, active-low.
- STATUS_OUT  in  1  serial status data from the controller.
- STATUS_SEND  in  1  frame-start strobe from the controller.
- KB_IN  out  2  key digit to the controller.
- KB_RECV  out  1  digit-valid strobe to the controller.
- digit_in  in  2  digit from the local key matrix.
- digit_push  in  1  one-cycle strobe that stores digit_in.
- submit  in  1  one-cycle strobe that starts transmission of the buffer.
- clear  in  1  one-cycle strobe that empties the buffer.
- busy  out  1  high while transmitting.
- buf_count  out  3  number of digits buffered, 0..DIGITS.
- buf_full  out  1  buf_count==DIGITS.
- armed, alarm, sensor1, sensor2  out  1 each  last valid status frame.
- status_valid  out  1  one-cycle pulse when the flags update.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (RESET_IN=0 at a CLK edge): all outputs 0, KB_IN=00, buffer empty, both FSMs idle.
  - Reset mid-frame discards the partial frame.
  - Reset mid-transmission drives KB_RECV=0 from the next cycle; no further digits are sent.
- Status frame format:
  - The cycle with STATUS_SEND=1 carries bit3 on STATUS_OUT; the next three cycles carry bit2, bit1, bit0 (MSB first).
  - Bit mapping: bit3=armed, bit2=alarm, bit1=sensor1, bit0=sensor2.
- RX FSM states: R_IDLE, R_SHIFT (2-bit bit counter).
  - R_IDLE: on STATUS_SEND=1, capture bit3 and go to R_SHIFT with 3 bits remaining.
  - R_SHIFT: capture one bit per cycle. After bit0 is captured, go to R_IDLE.
  - On the cycle after bit0: load armed/alarm/sensor1/sensor2 and pulse status_valid. Latency is 1 cycle after the last data bit.
  - STATUS_SEND=1 while in R_SHIFT: pulse frame_err, discard the partial frame, treat this cycle as bit3 of a new frame. Flags keep their previous values.
  - Flags hold between frames; the idle-gap length is not checked.
- Digit buffer: FIFO of DIGITS 2-bit entries, sent in entry order.
  - digit_push with !busy and count<DIGITS: store digit_in, count+1.
  - digit_push while full or busy: ignored, buffer unchanged.
  - clear with !busy: count=0. clear while busy: ignored.
  - Same cycle, clear and push: clear wins, the pushed digit is dropped.
  - Same cycle, submit and push: submit wins, the pushed digit is dropped.
  - Same cycle, submit and clear: submit wins.
- TX FSM states: T_IDLE, T_DIGIT, T_GAP.
  - T_IDLE: KB_RECV=0, KB_IN=00, busy=0.
    - submit with count>0: go to T_DIGIT at digit index 0; busy=1 from the next cycle.
    - submit with count=0: ignored.
  - T_DIGIT: for exactly one cycle, KB_RECV=1 and KB_IN=buffer[index]; then go to T_GAP.
  - T_GAP: KB_RECV=0, KB_IN=00 for KEY_GAP cycles.
    - If more digits remain: index+1, go to T_DIGIT.
    - Otherwise: count=0, busy=0, go to T_IDLE.
  - A partial code (count<DIGITS) is sent as-is; code validity is judged by the controller.
- The RX and TX paths are fully independent and may be active in the same cycle.

Test Plan:
- Reset: hold RESET_IN=0 for 2 cycles with random inputs -> all outputs 0, KB_IN=00, buf_count=0.
- Status frame: STATUS_SEND pulse with STATUS_OUT sequence 1,0,1,0 -> one cycle after the 4th bit: armed=1, alarm=0, sensor1=1, sensor2=0, status_valid high for exactly 1 cycle. A second frame 1,1,0,0 -> alarm=1, sensor1=0.
- Frame abort: STATUS_SEND again on the 3rd bit of a frame -> frame_err pulses once, flags unchanged; the new frame 0,0,0,1 completes -> armed=0, sensor2=1.
- Key transmit: push 0,1,2,3, then submit -> KB_RECV pulses 4 times, each followed by 1 idle cycle, with KB_IN=00,01,10,11 on the strobe cycles; busy spans 8 cycles; buf_count=0 afterwards.
- Buffer edges: push 5 digits -> buf_full=1, count=4, 5th digit dropped. submit with count=0 -> no KB_RECV. clear+push in the same cycle -> count=0.
- Mid-transmission events: push/clear during busy -> ignored. Reset after 2nd digit -> KB_RECV stays 0, count=0.
